// File: rtl/dco_trim_sequencer.sv
// Start-up and trim-slew sequencer for the 13-stage trimmable ring oscillator.
// Walks the 26-bit thermometer-style trim word one bit per step toward a requested trim count.
module dco_trim_sequencer #(
    parameter int STEP_DIV  = 16,
    parameter int START_CYC = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        en,
    input  logic [4:0]  target,
    input  logic        target_valid,
    output logic        target_ready,
    output logic        osc_enable,
    output logic        osc_run,
    output logic [25:0] trim,
    output logic [4:0]  count,
    output logic        busy,
    output logic        settled
);

    localparam int TIMER_MAX = (STEP_DIV > START_CYC) ? STEP_DIV : START_CYC;
    localparam int TW        = (TIMER_MAX > 1) ? $clog2(TIMER_MAX) : 1;
    localparam logic [4:0] COUNT_MAX = 5'd26;

    typedef enum logic [1:0] {
        S_OFF,
        S_START,
        S_IDLE,
        S_SLEW
    } state_t;

    state_t      state, state_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic [4:0]  tgt, tgt_nxt;
    logic [4:0]  count_nxt;
    logic [4:0]  clamped;
    logic [25:0] trim_nxt;
    logic        ready_nxt, enable_nxt, run_nxt, busy_nxt, settled_nxt;

    // Primary bits fill first; secondary bits start once all 13 primaries are set.
    function automatic logic [25:0] decode(input logic [4:0] n);
        logic [25:0] w;
        w = '0;
        for (int i = 0; i < 13; i++) begin
            w[i]      = (5'(i) < n);
            w[13 + i] = (5'(i + 13) < n);
        end
        return w;
    endfunction

    assign clamped = (target > COUNT_MAX) ? COUNT_MAX : target;

    // NOTE: every signal gets its default before the case statement so no path leaves it unassigned (no latches).
    always_comb begin
        state_nxt   = state;
        timer_nxt   = timer;
        tgt_nxt     = tgt;
        count_nxt   = count;
        ready_nxt   = target_ready;
        enable_nxt  = osc_enable;
        run_nxt     = osc_run;
        busy_nxt    = busy;
        settled_nxt = 1'b0;

        if (!en) begin
            state_nxt  = S_OFF;
            timer_nxt  = '0;
            tgt_nxt    = '0;
            count_nxt  = '0;
            ready_nxt  = 1'b0;
            enable_nxt = 1'b0;
            run_nxt    = 1'b0;
            busy_nxt   = 1'b0;
        end else begin
            case (state)
                S_OFF: begin
                    state_nxt  = S_START;
                    enable_nxt = 1'b1;
                    run_nxt    = 1'b0;
                    busy_nxt   = 1'b1;
                    ready_nxt  = 1'b0;
                    timer_nxt  = TW'(START_CYC - 1);
                end
                S_START: begin
                    if (timer == '0) begin
                        state_nxt = S_IDLE;
                        run_nxt   = 1'b1;
                        busy_nxt  = 1'b0;
                        ready_nxt = 1'b1;
                    end else begin
                        timer_nxt = timer - 1'b1;
                    end
                end
                S_IDLE: begin
                    ready_nxt = 1'b1;
                    if (target_valid && target_ready) begin
                        tgt_nxt   = clamped;
                        ready_nxt = 1'b0;
                        if (clamped == count) begin
                            settled_nxt = 1'b1;
                        end else begin
                            state_nxt = S_SLEW;
                            busy_nxt  = 1'b1;
                            timer_nxt = TW'(STEP_DIV - 1);
                        end
                    end
                end
                S_SLEW: begin
                    ready_nxt = 1'b0;
                    if (timer == '0) begin
                        count_nxt = (tgt > count) ? count + 5'd1 : count - 5'd1;
                        timer_nxt = TW'(STEP_DIV - 1);
                        if (count_nxt == tgt) begin
                            state_nxt   = S_IDLE;
                            busy_nxt    = 1'b0;
                            settled_nxt = 1'b1;
                            ready_nxt   = 1'b1;
                        end
                    end else begin
                        timer_nxt = timer - 1'b1;
                    end
                end
                default: state_nxt = S_OFF;
            endcase
        end

        // Decoding the next count keeps trim registered and in step with count.
        trim_nxt = decode(count_nxt);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= S_OFF;
            timer        <= '0;
            tgt          <= '0;
            count        <= '0;
            trim         <= '0;
            target_ready <= 1'b0;
            osc_enable   <= 1'b0;
            osc_run      <= 1'b0;
            busy         <= 1'b0;
            settled      <= 1'b0;
        end else begin
            state        <= state_nxt;
            timer        <= timer_nxt;
            tgt          <= tgt_nxt;
            count        <= count_nxt;
            trim         <= trim_nxt;
            target_ready <= ready_nxt;
            osc_enable   <= enable_nxt;
            osc_run      <= run_nxt;
            busy         <= busy_nxt;
            settled      <= settled_nxt;
        end
    end

endmodule

// File: tb/tb_dco_trim_sequencer.sv
// Scoreboard bench for dco_trim_sequencer: requests push expected settle results,
// a negedge monitor pops and compares them and watches single-bit trim transitions.
module tb_dco_trim_sequencer;

    localparam int STEP_DIV  = 16;
    localparam int START_CYC = 8;

    logic        clock;
    logic        reset;
    logic        en;
    logic [4:0]  target;
    logic        target_valid;
    logic        target_ready;
    logic        osc_enable;
    logic        osc_run;
    logic [25:0] trim;
    logic [4:0]  count;
    logic        busy;
    logic        settled;

    dco_trim_sequencer #(.STEP_DIV(STEP_DIV), .START_CYC(START_CYC)) dut (
        .clock        (clock),
        .reset        (reset),
        .en           (en),
        .target       (target),
        .target_valid (target_valid),
        .target_ready (target_ready),
        .osc_enable   (osc_enable),
        .osc_run      (osc_run),
        .trim         (trim),
        .count        (count),
        .busy         (busy),
        .settled      (settled)
    );

    typedef struct {
        int          count;
        logic [25:0] trim;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          model_count = 0;
    logic [25:0] prev_trim = '0;

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    endtask

    // Reference trim word: n ones, primaries (bits 0..12) before secondaries (bits 13..25).
    function automatic logic [25:0] model_trim(input int n);
        if (n <= 13) return 26'((32'd1 << n) - 32'd1);
        return 26'h1FFF | 26'(((32'd1 << (n - 13)) - 32'd1) << 13);
    endfunction

    // Monitor: settle pulses against the scoreboard, plus trim-transition invariants.
    always @(negedge clock) begin
        exp_t e;
        if (settled) begin
            if (exp_q.size() == 0) begin
                check("unexpected_settled", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("settle_count", 32'(count), 32'(e.count));
                check("settle_trim",  32'(trim),  32'(e.trim));
                check("settle_cycle", 32'(cyc),   32'(e.cyc));
                check("settle_busy",  32'(busy),  32'd0);
            end
        end
        if (trim !== prev_trim) begin
            if (osc_enable) check("trim_hamming", 32'($countones(trim ^ prev_trim)), 32'd1);
            check("count_popcount", 32'(count), 32'($countones(trim)));
        end
        prev_trim = trim;
    end

    task automatic startup();
        int en_cyc;
        int rise_cyc;
        int n;
        @(posedge clock); #1;
        en = 1'b1;
        en_cyc = cyc;
        n = 0;
        do begin @(negedge clock); n++; end while (!osc_enable && n < 100);
        rise_cyc = cyc;
        check("osc_enable_rise_cycle", 32'(rise_cyc), 32'(en_cyc + 1));
        check("start_busy",    32'(busy),    32'd1);
        check("start_run_low", 32'(osc_run), 32'd0);
        n = 0;
        do begin @(negedge clock); n++; end while (!osc_run && n < 100);
        check("osc_run_delay", 32'(cyc - rise_cyc), 32'(START_CYC));
        check("idle_ready", 32'(target_ready), 32'd1);
        check("idle_busy",  32'(busy),         32'd0);
        check("idle_trim",  32'(trim),         32'd0);
        model_count = 0;
    endtask

    task automatic request(input int t);
        int n;
        int tgt;
        int k;
        exp_t e;
        @(posedge clock); #1;
        target = 5'(t);
        target_valid = 1'b1;
        n = 0;
        do begin @(negedge clock); n++; end while (!target_ready && n < 1000);
        if (!target_ready) begin
            check("ready_timeout", 32'd0, 32'd1);
            target_valid = 1'b0;
            return;
        end
        tgt = (t > 26) ? 26 : t;
        k = (tgt > model_count) ? tgt - model_count : model_count - tgt;
        e.count = tgt;
        e.trim  = model_trim(tgt);
        e.cyc   = cyc + 1 + STEP_DIV * k;
        exp_q.push_back(e);
        model_count = tgt;
        @(posedge clock); #1;
        target_valid = 1'b0;
        target = 5'($urandom_range(0, 31));
    endtask

    task automatic wait_settle();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(negedge clock);
            n++;
        end
        if (exp_q.size() != 0) begin
            check("settle_timeout", 32'd0, 32'd1);
            exp_q.delete();
        end
    endtask

    initial begin
        int n;
        reset = 1'b1;
        en = 1'b0;
        target = '0;
        target_valid = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_osc_enable", 32'(osc_enable),   32'd0);
        check("rst_osc_run",    32'(osc_run),      32'd0);
        check("rst_trim",       32'(trim),         32'd0);
        check("rst_count",      32'(count),        32'd0);
        check("rst_ready",      32'(target_ready), 32'd0);
        check("rst_busy",       32'(busy),         32'd0);
        check("rst_settled",    32'(settled),      32'd0);
        reset = 1'b0;
        startup();

        // Slew up within the primary bits, then across the primary/secondary boundary.
        request(5);  wait_settle();
        request(12); wait_settle();
        request(15); wait_settle();
        @(negedge clock);
        check("trim_after_15", 32'(trim), 32'h0007FFF);

        // Full scale, then an over-range request that clamps to the current count.
        request(26); wait_settle();
        request(31); wait_settle();
        @(negedge clock);
        check("trim_full_scale", 32'(trim), 32'h3FFFFFF);

        // Shut down mid-slew: everything clears on the next edge and no settle pulse follows.
        request(20); wait_settle();
        request(2);
        n = 0;
        while (count != 5'd10 && n < 1000) begin @(negedge clock); n++; end
        check("reached_count_10", 32'(count), 32'd10);
        en = 1'b0;
        @(posedge clock); #1;
        check("off_trim",       32'(trim),       32'd0);
        check("off_osc_run",    32'(osc_run),    32'd0);
        check("off_osc_enable", 32'(osc_enable), 32'd0);
        check("off_count",      32'(count),      32'd0);
        check("off_busy",       32'(busy),       32'd0);
        exp_q.delete();
        repeat (40) @(negedge clock);
        startup();

        // A request held during SLEW waits for IDLE and is then accepted.
        request(3);
        @(negedge clock);
        check("slew_ready_low", 32'(target_ready), 32'd0);
        check("slew_busy",      32'(busy),         32'd1);
        request(7);
        wait_settle();

        // Asynchronous reset in the middle of a slew.
        request(20);
        repeat (30) @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        check("async_rst_trim",  32'(trim),       32'd0);
        check("async_rst_count", 32'(count),      32'd0);
        check("async_rst_busy",  32'(busy),       32'd0);
        check("async_rst_run",   32'(osc_run),    32'd0);
        check("async_rst_en",    32'(osc_enable), 32'd0);
        exp_q.delete();
        en = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        startup();

        // Random targets, including over-range values.
        for (int i = 0; i < 16; i++) begin
            request(int'($urandom_range(0, 31)));
            wait_settle();
        end

        repeat (5) @(negedge clock);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
